// File: rtl/uart_bus_loader.sv
`default_nettype none
// =============================================================================
// uart_bus_loader : UART command parser issuing single-word bus reads/writes.
// Optional trailing XOR checksum byte: define UART_LOADER_CHECKSUM_EN.
// Revision: 1.0
// =============================================================================

module uart_bus_loader #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [31:0] mem_rdata,
    output logic        cpu_hold,
    output logic        busy
);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;
    localparam int         TW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ADDR  = 4'd1,
        DATA  = 4'd2,
`ifdef UART_LOADER_CHECKSUM_EN
        CSUM  = 4'd3,
`endif
        EXEC  = 4'd4,
        RDLAT = 4'd5,
        SEND  = 4'd6,
        GAP   = 4'd7,
        SWAIT = 4'd8
    } state_t;

    state_t        state;
    logic [1:0]    cnt;
    logic [1:0]    left;
    logic [7:0]    cmd;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   bus_addr;
    logic [23:0]   reply;
    logic [TW-1:0] timer;
    logic          bad;

    logic          is_cmd;
    logic          is_hg;
    logic          in_field;
    logic          launch;
    logic          csum_ok;
    logic [7:0]    cmd_nx;
    logic [31:0]   addr_nx;
    logic [31:0]   wdata_nx;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
    assign csum_ok  = (rx_data == csum);
    assign in_field = (state == ADDR) || (state == DATA) || (state == CSUM);
    assign launch   = rx_valid && (state == CSUM);
`else
    assign csum_ok  = 1'b1;
    assign in_field = (state == ADDR) || (state == DATA);
    assign launch   = rx_valid && (((state == IDLE) && is_hg) ||
                                   ((state == ADDR) && (cnt == 2'd3) && (cmd == CMD_R)) ||
                                   ((state == DATA) && (cnt == 2'd3)));
`endif

    assign is_hg    = (rx_data == CMD_H) || (rx_data == CMD_G);
    assign is_cmd   = is_hg || (rx_data == CMD_W) || (rx_data == CMD_R);
    assign cmd_nx   = (state == IDLE) ? rx_data : cmd;
    assign addr_nx  = (state == ADDR) ? {rx_data, addr[31:8]}  : addr;
    assign wdata_nx = (state == DATA) ? {rx_data, wdata[31:8]} : wdata;

    // The transmitter may still be busy when SEND is entered, so the strobe
    // has to be qualified by tx_busy in the same cycle.
    assign tx_en    = (state == SEND) && !tx_busy;
    assign busy     = (state != IDLE);
    assign mem_addr = {32'd0, bus_addr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            left      <= 2'd0;
            cmd       <= 8'd0;
            addr      <= 32'd0;
            wdata     <= 32'd0;
            bus_addr  <= 32'd0;
            reply     <= 24'd0;
            timer     <= '0;
            bad       <= 1'b0;
            tx_data   <= 8'd0;
            mem_wdata <= 32'd0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            cpu_hold  <= 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            mem_wen <= 1'b0;
            mem_ren <= 1'b0;

            // Inter-byte timeout while a packet is being collected
            if (in_field) begin
                if (rx_valid) begin
                    timer <= '0;
                end else if (timer == TIMER_LAST) begin
                    timer <= '0;
                    state <= IDLE;
                end else begin
                    timer <= timer + TW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (rx_valid && is_cmd) begin
                        cmd   <= rx_data;
                        cnt   <= 2'd0;
                        timer <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum  <= rx_data;
                        state <= is_hg ? CSUM : ADDR;
`else
                        state <= is_hg ? EXEC : ADDR;
`endif
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        addr <= addr_nx;
                        cnt  <= cnt + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
                        if (cnt == 2'd3)
                            state <= (cmd == CMD_W) ? DATA : CSUM;
`else
                        if (cnt == 2'd3)
                            state <= (cmd == CMD_W) ? DATA : EXEC;
`endif
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        wdata <= wdata_nx;
                        cnt   <= cnt + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum  <= csum ^ rx_data;
                        if (cnt == 2'd3)
                            state <= CSUM;
`else
                        if (cnt == 2'd3)
                            state <= EXEC;
`endif
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (rx_valid)
                        state <= EXEC;
                end
`endif
                EXEC: begin
                    if ((cmd == CMD_R) && !bad) begin
                        state <= RDLAT;
                    end else begin
                        tx_data <= bad ? NAK : ACK;
                        left    <= 2'd0;
                        state   <= SEND;
                    end
                end
                RDLAT: begin
                    tx_data <= mem_rdata[7:0];
                    reply   <= mem_rdata[31:8];
                    left    <= 2'd3;
                    state   <= SEND;
                end
                SEND: begin
                    if (!tx_busy)
                        state <= GAP;
                end
                GAP: begin
                    state <= SWAIT;
                end
                SWAIT: begin
                    if (!tx_busy) begin
                        if (left == 2'd0) begin
                            state <= IDLE;
                        end else begin
                            tx_data <= reply[7:0];
                            reply   <= {8'd0, reply[23:8]};
                            left    <= left - 2'd1;
                            state   <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Bus access / hold update is issued the cycle after the final byte
            if (launch) begin
                bad <= !csum_ok;
                if (csum_ok) begin
                    case (cmd_nx)
                        CMD_W: begin
                            mem_wen   <= 1'b1;
                            bus_addr  <= addr_nx;
                            mem_wdata <= wdata_nx;
                        end
                        CMD_R: begin
                            mem_ren  <= 1'b1;
                            bus_addr <= addr_nx;
                        end
                        CMD_H:   cpu_hold <= 1'b1;
                        CMD_G:   cpu_hold <= 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_loader.sv
`default_nettype none
// Directed bench for uart_bus_loader with a simple bus memory and UART tx model.

module tb_uart_bus_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rdata = 32'd0;
    logic        cpu_hold;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    int txn = 0;
    logic [7:0]  tx_bytes [0:63];
    int          tx_cycs  [0:63];
    int wen_n = 0, ren_n = 0;
    int wen_cyc = 0, ren_cyc = 0, hold_fall_cyc = 0, hold_rise_cyc = 0;
    logic [63:0] wen_addr = 0, ren_addr = 0;
    logic [31:0] wen_data = 0;
    logic        prev_hold = 1'b1;
    logic [7:0]  pkt_x = 8'd0;
    int          busy_cnt = 0;
    int          base;

    uart_bus_loader #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_ren(mem_ren), .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter: busy for 6 cycles after accepting a byte
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (tx_en) busy_cnt <= 6;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(posedge clk)
        if (mem_ren) mem_rdata <= (mem_addr == 64'h1000) ? 32'h1234_5678 : 32'h0BAD_F00D;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (tx_en) begin
            check("tx_en_while_busy", {63'd0, tx_busy}, 64'd0);
            if (txn < 64) begin
                tx_bytes[txn] = tx_data;
                tx_cycs[txn]  = cyc;
            end
            txn = txn + 1;
        end
        if (mem_wen && mem_ren) check("wen_ren_together", 64'd1, 64'd0);
        if (mem_wen) begin wen_n++; wen_cyc = cyc; wen_addr = mem_addr; wen_data = mem_wdata; end
        if (mem_ren) begin ren_n++; ren_cyc = cyc; ren_addr = mem_addr; end
        if (prev_hold && !cpu_hold) hold_fall_cyc = cyc;
        if (!prev_hold && cpu_hold) hold_rise_cyc = cyc;
        prev_hold = cpu_hold;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        last_rx_cyc = cyc;
        pkt_x = pkt_x ^ b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic start_pkt(input logic [7:0] c);
        pkt_x = 8'd0;
        send_byte(c);
    endtask

    task automatic end_pkt();
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(pkt_x);
`endif
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 600 && txn < n; i++) @(negedge clk);
        check("tx_count", txn, n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && busy; i++) @(negedge clk);
        check("return_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_wen_ren", {mem_wen, mem_ren}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_tx_data", tx_data, 0);

        // Write 0xDEADBEEF to 0x1000
        base = txn;
        start_pkt(8'h57); send_word(32'h0000_1000); send_word(32'hDEAD_BEEF); end_pkt();
        wait_tx(base + 1);
        wait_idle();
        check("wr_count", wen_n, 1);
        check("wr_addr", wen_addr, 64'h0000_0000_0000_1000);
        check("wr_data", wen_data, 32'hDEAD_BEEF);
        check("wr_strobe_cycle", wen_cyc, last_rx_cyc + 1);
        check("wr_ack", tx_bytes[base], 8'h06);
        check("wr_ack_cycle", tx_cycs[base], last_rx_cyc + 2);
        check("wr_no_read", ren_n, 0);

        // Read 0x1000
        base = txn;
        start_pkt(8'h52); send_word(32'h0000_1000); end_pkt();
        wait_tx(base + 4);
        wait_idle();
        check("rd_count", ren_n, 1);
        check("rd_addr", ren_addr, 64'h1000);
        check("rd_strobe_cycle", ren_cyc, last_rx_cyc + 1);
        check("rd_first_tx_cycle", tx_cycs[base], last_rx_cyc + 3);
        check("rd_bytes", {tx_bytes[base+3], tx_bytes[base+2], tx_bytes[base+1], tx_bytes[base]},
              32'h1234_5678);

        // G then H
        base = txn;
        start_pkt(8'h47); end_pkt();
        wait_tx(base + 1);
        wait_idle();
        check("g_hold", cpu_hold, 0);
        check("g_hold_cycle", hold_fall_cyc, last_rx_cyc + 1);
        check("g_ack", tx_bytes[base], 8'h06);
        check("g_ack_cycle", tx_cycs[base], last_rx_cyc + 2);
        base = txn;
        start_pkt(8'h48); end_pkt();
        wait_tx(base + 1);
        wait_idle();
        check("h_hold", cpu_hold, 1);
        check("h_hold_cycle", hold_rise_cyc, last_rx_cyc + 1);
        check("h_ack", tx_bytes[base], 8'h06);

        // Partial write abandoned by the inter-byte timeout
        base = txn;
        start_pkt(8'h57); send_byte(8'h00); send_byte(8'h10);
        while (cyc < last_rx_cyc + 100) @(negedge clk);
        check("to_busy_last_cycle", busy, 1);
        @(negedge clk);
        check("to_idle_after", busy, 0);
        start_pkt(8'h52); send_word(32'h0000_0000); end_pkt();
        wait_tx(base + 4);
        wait_idle();
        check("to_no_write", wen_n, 1);
        check("to_rd_addr", ren_addr, 64'h0);
        check("to_rd_bytes", {tx_bytes[base+3], tx_bytes[base+2], tx_bytes[base+1], tx_bytes[base]},
              32'h0BAD_F00D);

        // Release hold so the reset below has something to restore
        base = txn;
        start_pkt(8'h47); end_pkt();
        wait_tx(base + 1);
        wait_idle();
        check("g2_hold", cpu_hold, 0);

        // Unknown command byte, then a read interrupted by reset
        send_byte(8'hAA);
        @(negedge clk);
        check("unknown_ignored", busy, 0);
        base = txn;
        start_pkt(8'h52); send_word(32'h0000_1000); end_pkt();
        wait_tx(base + 2);
        check("rst_test_byte0", tx_bytes[base], 8'h78);
        check("rst_test_byte1", tx_bytes[base+1], 8'h56);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_tx_en", tx_en, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_strobes", {mem_wen, mem_ren}, 0);
        check("mid_rst_hold", cpu_hold, 1);
        check("mid_rst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_no_tx", txn, base + 2);

`ifdef UART_LOADER_CHECKSUM_EN
        // Valid G (47 47), then write with a bad checksum byte
        base = txn;
        send_byte(8'h47); send_byte(8'h47);
        wait_tx(base + 1);
        wait_idle();
        check("cs_g_hold", cpu_hold, 0);
        check("cs_g_ack", tx_bytes[base], 8'h06);
        base = txn;
        send_byte(8'h57); send_word(32'h0000_1000); send_word(32'h0000_0001); send_byte(8'h00);
        wait_tx(base + 1);
        wait_idle();
        check("cs_bad_no_write", wen_n, 1);
        check("cs_bad_nak", tx_bytes[base], 8'h15);
        check("cs_bad_hold", cpu_hold, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/uart_bus_loader.md
# uart_bus_loader

UART-driven bus initiator: parses a byte-level command protocol from the UART receiver and issues single-word reads and writes on the CPU-side memory bus. It also transmits replies through the UART transmitter. It is the host-facing end of the CPU/UART link, used to load program images and peek or poke memory while the CPU is held in reset. It sits between `uart_rx`/`uart_tx` and the memory bus mux.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles allowed between bytes of one packet before it is discarded.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `rx_valid` input, 1 bit: one-cycle strobe; `rx_data` holds a received byte.
- `rx_data` input, 8 bits: received byte.
- `tx_en` output, 1 bit: one-cycle request to send `tx_data`.
- `tx_data` output, 8 bits: byte to transmit.
- `tx_busy` input, 1 bit: transmitter busy.
- `mem_addr` output, 64 bits: bus address; the 32-bit packet address, zero-extended.
- `mem_wdata` output, 32 bits: write data.
- `mem_wen` output, 1 bit: one-cycle write strobe.
- `mem_ren` output, 1 bit: one-cycle read strobe.
- `mem_rdata` input, 32 bits: read data, valid the cycle after `mem_ren`.
- `cpu_hold` output, 1 bit: holds the CPU in reset while high.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- Packets. Multi-byte fields are little-endian.
  - `W` (0x57): 4 address bytes, then 4 data bytes. Performs a bus write, then replies 0x06.
  - `R` (0x52): 4 address bytes. Performs a bus read, then replies with 4 data bytes, LSB first.
  - `H` (0x48): sets `cpu_hold`=1, replies 0x06.
  - `G` (0x47): clears `cpu_hold`=0, replies 0x06.
- Unknown command byte in IDLE: ignored; no reply, no state change.
- States:
  - IDLE: next state from the command byte.
  - ADDR: counts 0..3.
  - DATA: counts 0..3; entered for `W` only.
  - CSUM: present only with the macro.
  - EXEC: pulses `mem_wen` or `mem_ren`, or updates `cpu_hold`.
  - RDLAT: latches `mem_rdata`.
  - SEND: pulses `tx_en`.
  - GAP: one cycle; `tx_busy` is ignored.
  - SWAIT: waits for `tx_busy`=0.
  - After the last reply byte, SWAIT returns to IDLE.
- Transmit handshake: `tx_en` is asserted only when `tx_busy`=0, for exactly one cycle. The next byte is sent only after GAP and SWAIT.
- Bytes received in EXEC, RDLAT, SEND, GAP or SWAIT are dropped. The protocol is half-duplex.
- Timeout: a counter clears on every `rx_valid` while in ADDR, DATA or CSUM. When it reaches `TIMEOUT_CYCLES`-1 the block returns to IDLE. No bus access, no reply.
- `mem_addr` and `mem_wdata` hold their last values between accesses. `mem_wen` and `mem_ren` are never high together.
- Reset values:
  - `tx_en`=0, `tx_data`=0.
  - `mem_addr`=0, `mem_wdata`=0, `mem_wen`=0, `mem_ren`=0.
  - `cpu_hold`=1, `busy`=0.
  - State IDLE, all counters 0.
- Reset mid-packet or mid-reply discards everything in progress. The transmitter completes any byte it has already accepted.

## Timing
- Let N be the cycle of the final byte's `rx_valid`.
- Write: `mem_wen`=1 in cycle N+1; earliest ack `tx_en` in N+2.
- Read: `mem_ren`=1 in N+1; `mem_rdata` sampled at N+2; earliest first `tx_en` in N+3.
- `H` and `G`: `cpu_hold` changes in N+1; earliest ack `tx_en` in N+2.
- If `tx_busy`=1 when SEND is entered, `tx_en` is delayed until the first cycle with `tx_busy`=0.
- Timeout: the return to IDLE happens exactly `TIMEOUT_CYCLES` cycles after the last accepted `rx_valid`.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined:
  - Every packet carries one trailing byte equal to the XOR of all preceding packet bytes, including the command byte.
  - On match: normal execution.
  - On mismatch: no bus access, no `cpu_hold` change; reply 0x15, then IDLE.
  - The timeout also covers the wait for the checksum byte.
- Not defined: no CSUM state; execution starts after the last field byte.

## Test plan
- After reset: `cpu_hold`=1, `busy`=0, all strobes 0. Send 57 00 10 00 00 EF BE AD DE → one `mem_wen` pulse with `mem_addr`=0x0000_0000_0000_1000 and `mem_wdata`=0xDEADBEEF, then one reply byte 0x06.
- Memory model returns 0x12345678 for address 0x1000. Send 52 00 10 00 00 → one `mem_ren` pulse, then reply 78 56 34 12, each `tx_en` pulse occurring only while `tx_busy`=0.
- Send 47 → `cpu_hold` falls in N+1, reply 0x06. Then send 48 → `cpu_hold`=1, reply 0x06.
- With `TIMEOUT_CYCLES`=100, send 57 00 10, then idle 100 cycles, then 52 00 00 00 00 → no write occurs; the read of address 0 completes normally.
- Send 0xAA, then 52 00 10 00 00 → 0xAA is ignored; the read completes. Assert `rst_n`=0 during the second reply byte → no further `tx_en` pulses, outputs at reset values.
- With the macro defined: send 47 47 → `cpu_hold`=0, reply 0x06. Then send 57 00 10 00 00 01 00 00 00 00 (bad checksum) → no `mem_wen`, reply 0x15.
